// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, two write ports, scoreboard set and clear-sweep control.
// The execute stage drives through 'master'; the register file attaches to 'slave'.
interface regfile_mp_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NREAD = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic                  init_start;
    logic                  init_busy;

    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_pend;

    logic                  wa_en;
    logic [AW-1:0]         wa_addr;
    logic [XLEN-1:0]       wa_data;

    logic                  wb_en;
    logic [AW-1:0]         wb_addr;
    logic [XLEN-1:0]       wb_data;

    logic                  sb_set_en;
    logic [AW-1:0]         sb_set_addr;

    logic                  wr_collision;

    modport master (
        output init_start,
        output rd_addr,
        output wa_en, wa_addr, wa_data,
        output wb_en, wb_addr, wb_data,
        output sb_set_en, sb_set_addr,
        input  init_busy,
        input  rd_data,
        input  rd_pend,
        input  wr_collision
    );

    modport slave (
        input  init_start,
        input  rd_addr,
        input  wa_en, wa_addr, wa_data,
        input  wb_en, wb_addr, wb_data,
        input  sb_set_en, sb_set_addr,
        output init_busy,
        output rd_data,
        output rd_pend,
        output wr_collision
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NREAD bypassed read ports, two prioritised write ports,
// a pending-write scoreboard and a clear sequencer that zeroes the array after reset or on request.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NREAD    = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    regfile_mp_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic {StIdle, StSweep} state_e;

    state_e            state_q;
    logic              busy_q;
    logic [AW-1:0]     cnt_q;
    logic [NREGS-1:0]  pend_q;
    logic [NREGS-1:0]  pend_d;
    logic              coll_q;
    logic              coll_d;
    logic [XLEN-1:0]   mem_q [NREGS];

    logic              we_a;
    logic              we_b;
    logic              sb_set;
    logic              sweep_last;

    // Writes to the hardwired zero register are not effective: no storage, no scoreboard clear.
    assign we_a = bus.wa_en && !busy_q && !(ZERO_REG && (bus.wa_addr == '0));
    assign we_b = bus.wb_en && !busy_q && !(ZERO_REG && (bus.wb_addr == '0));

    assign sb_set = bus.sb_set_en && !busy_q && !(ZERO_REG && (bus.sb_set_addr == '0));

    assign coll_d = we_a && we_b && (bus.wa_addr == bus.wb_addr);

    assign sweep_last = (cnt_q == AW'(NREGS - 1));

    // A set and a clear of the same register in one cycle leave it set.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if ((we_a && (bus.wa_addr == AW'(i))) || (we_b && (bus.wb_addr == AW'(i)))) begin
                pend_d[i] = 1'b0;
            end
            if (sb_set && (bus.sb_set_addr == AW'(i))) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StSweep;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            pend_q  <= '0;
            coll_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            coll_q <= coll_d;
            unique case (state_q)
                StIdle: begin
                    if (bus.init_start) begin
                        state_q <= StSweep;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        pend_q  <= '0;
                    end
                end
                StSweep: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (sweep_last) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Array has no reset; the sweep is the only way it is cleared. B overrides A on a shared address.
    always_ff @(posedge clk) begin
        if (busy_q) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (we_a && !(we_b && (bus.wb_addr == bus.wa_addr))) begin
                mem_q[bus.wa_addr] <= bus.wa_data;
            end
            if (we_b) begin
                mem_q[bus.wb_addr] <= bus.wb_data;
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            zero;
        logic            hit_a;
        logic            hit_b;
        logic [XLEN-1:0] data;

        assign addr  = bus.rd_addr[k*AW +: AW];
        assign zero  = busy_q || (ZERO_REG && (addr == '0));
        assign hit_a = we_a && (bus.wa_addr == addr);
        assign hit_b = we_b && (bus.wb_addr == addr);

        always_comb begin
            data = mem_q[addr];
            if (zero) begin
                data = '0;
            end else if (hit_b) begin
                data = bus.wb_data;
            end else if (hit_a) begin
                data = bus.wa_data;
            end
        end

        assign bus.rd_data[k*XLEN +: XLEN] = data;
        assign bus.rd_pend[k]              = !zero && pend_q[addr] && !hit_a && !hit_b;
    end

    assign bus.init_busy    = busy_q;
    assign bus.wr_collision = coll_q;

endmodule
